// File: rtl/port_arbiter_pkg.sv
// Shared definitions for the wormhole output-port arbiter.
package port_arbiter_pkg;

  localparam int unsigned DEF_PORTS_NUM = 4;
  localparam int unsigned DEF_DATA_SIZE = 37;

  // A port bundle is {valid, last, data}; flags sit directly above the payload.
  localparam int unsigned FLAG_BITS = 2;
  localparam int unsigned LAST_OFS  = 0;
  localparam int unsigned VALID_OFS = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Width of a full port bundle for a given payload width.
  function automatic int unsigned port_size(input int unsigned data_size);
    return data_size + FLAG_BITS;
  endfunction

endpackage

// File: rtl/port_arbiter_rr.sv
// Rotating-priority picker: first requester after the pointer wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned k;

  // Scan ptr+1 .. ptr+N modulo N and take the first request seen.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = (32'(ptr_i) + i) % N;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Round-robin output-port arbiter with packet locking and registered output.
module port_arbiter
  import port_arbiter_pkg::*;
#(
  parameter int unsigned PORTS_NUM    = DEF_PORTS_NUM,
  parameter int unsigned DATA_SIZE    = DEF_DATA_SIZE,
  parameter int unsigned LOCK_TIMEOUT = 0
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [PORTS_NUM-1:0]                       req_i,
  input  logic [PORTS_NUM*DATA_SIZE-1:0]             data_i,
  input  logic [PORTS_NUM-1:0]                       last_i,
  output logic [PORTS_NUM-1:0]                       gnt_o,
  output logic [DATA_SIZE-1:0]                       data_o,
  output logic                                       valid_o,
  output logic                                       last_o,
  input  logic                                       ready_i,
  output logic [(PORTS_NUM > 1 ? $clog2(PORTS_NUM) : 1)-1:0] owner_o,
  output logic                                       locked_o,
  output logic                                       timeout_o
);

  localparam int unsigned OW        = (PORTS_NUM > 1) ? $clog2(PORTS_NUM) : 1;
  localparam int unsigned CW        = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int unsigned PORT_SIZE = port_size(DATA_SIZE);
  localparam int unsigned LAST_POS  = DATA_SIZE + LAST_OFS;
  localparam int unsigned VALID_POS = DATA_SIZE + VALID_OFS;

  state_e               state_q, state_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PORT_SIZE-1:0] out_q, out_d;
  logic                 timeout_q, timeout_d;

  logic [PORTS_NUM-1:0] arb_gnt_c;
  logic [OW-1:0]        arb_idx_c;
  logic                 arb_any_c;
  logic [PORTS_NUM-1:0] gnt_c;
  logic [OW-1:0]        sel_c;
  logic                 load_c;
  logic                 load_ok_c;
  logic [DATA_SIZE-1:0] flit_c;

  rr_arbiter #(
    .N  (PORTS_NUM),
    .IW (OW)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_c),
    .idx_o (arb_idx_c),
    .any_o (arb_any_c)
  );

  // The output register can take a new flit when empty or being drained.
  assign load_ok_c = !out_q[VALID_POS] || ready_i;

  // Lock FSM, grant selection, timeout counter and output register next state.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    timeout_d = 1'b0;
    gnt_c     = '0;
    sel_c     = owner_q;
    load_c    = 1'b0;
    flit_c    = '0;

    case (state_q)
      IDLE: begin
        if (load_ok_c && arb_any_c) begin
          gnt_c  = arb_gnt_c;
          sel_c  = arb_idx_c;
          load_c = 1'b1;
          cnt_d  = '0;
          if (last_i[arb_idx_c]) begin
            ptr_d = arb_idx_c;
          end else begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (load_ok_c && req_i[owner_q]) begin
          gnt_c[owner_q] = 1'b1;
          load_c         = 1'b1;
          cnt_d          = '0;
          if (last_i[owner_q]) begin
            state_d = IDLE;
            ptr_d   = owner_q;
          end
        end else if (LOCK_TIMEOUT > 0) begin
          if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_d   = IDLE;
            ptr_d     = owner_q;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned k = 0; k < PORTS_NUM; k++) begin
      if (sel_c == OW'(k)) flit_c = data_i[k*DATA_SIZE +: DATA_SIZE];
    end

    if (load_c) begin
      out_d[DATA_SIZE-1:0] = flit_c;
      out_d[LAST_POS]      = last_i[sel_c];
      out_d[VALID_POS]     = 1'b1;
      owner_d              = sel_c;
    end else if (out_q[VALID_POS] && ready_i) begin
      out_d[VALID_POS] = 1'b0;
      out_d[LAST_POS]  = 1'b0;
    end
  end

  // State and output register; reset drops any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= OW'(PORTS_NUM - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = rst_n ? gnt_c : '0;
  assign data_o    = out_q[DATA_SIZE-1:0];
  assign valid_o   = out_q[VALID_POS];
  assign last_o    = out_q[LAST_POS];
  assign owner_o   = owner_q;
  assign locked_o  = (state_q == LOCKED);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Scoreboard bench for port_arbiter with a behavioural reference model.
module tb_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DS = 37;
  localparam int unsigned TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_i;
  logic [N*DS-1:0] data_i;
  logic [N-1:0]    last_i;
  logic [N-1:0]    gnt_o;
  logic [DS-1:0]   data_o;
  logic            valid_o;
  logic            last_o;
  logic            ready_i;
  logic [1:0]      owner_o;
  logic            locked_o;
  logic            timeout_o;

  port_arbiter #(
    .PORTS_NUM    (N),
    .DATA_SIZE    (DS),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .data_i    (data_i),
    .last_i    (last_i),
    .gnt_o     (gnt_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .last_o    (last_o),
    .ready_i   (ready_i),
    .owner_o   (owner_o),
    .locked_o  (locked_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [DS-1:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];

  // Reference model: packet-level view of who owns the port and who is next.
  int   m_ptr, m_owner, m_cnt;
  bit   m_locked, m_valid, m_pulse;
  logic [N-1:0] last_gnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = N - 1;
    m_owner  = 0;
    m_cnt    = 0;
    m_locked = 0;
    m_valid  = 0;
    m_pulse  = 0;
    sb.delete();
  endtask

  // One clock cycle: drive inputs, check against model, advance the model.
  task automatic tick(input logic [N-1:0] rq, input logic [N-1:0] lt, input logic rdy);
    logic [N-1:0] eg;
    bit load_ok, nxt_pulse;
    int w;
    @(negedge clk);
    if (!rst_n) rst_n = 1'b1;
    req_i   = rq;
    last_i  = lt;
    ready_i = rdy;
    for (int k = 0; k < N; k++) data_i[k*DS +: DS] = DS'({$urandom(), $urandom()});
    #1;
    chk("valid_o",   64'(valid_o),   64'(m_valid));
    chk("locked_o",  64'(locked_o),  64'(m_locked));
    chk("timeout_o", 64'(timeout_o), 64'(m_pulse));
    chk("owner_o",   64'(owner_o),   64'(m_owner));

    load_ok   = !m_valid || rdy;
    eg        = '0;
    nxt_pulse = 0;
    w         = 0;
    if (!m_locked) begin
      if (load_ok) begin
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (rq[k]) begin
            eg[k] = 1'b1;
            w     = k;
            break;
          end
        end
      end
      if (eg != '0) begin
        sb.push_back('{owner: w, data: data_i[w*DS +: DS], last: lt[w]});
        m_owner = w;
        if (lt[w]) m_ptr = w;
        else begin
          m_locked = 1;
          m_cnt    = 0;
        end
      end
    end else begin
      if (load_ok && rq[m_owner]) begin
        eg[m_owner] = 1'b1;
        sb.push_back('{owner: m_owner, data: data_i[m_owner*DS +: DS], last: lt[m_owner]});
        m_cnt = 0;
        if (lt[m_owner]) begin
          m_locked = 0;
          m_ptr    = m_owner;
        end
      end else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_locked  = 0;
          m_ptr     = m_owner;
          nxt_pulse = 1;
          m_cnt     = 0;
        end
      end
    end
    chk("gnt_o", 64'(gnt_o), 64'(eg));
    if (eg != '0) m_valid = 1;
    else if (rdy) m_valid = 0;
    m_pulse  = nxt_pulse;
    last_gnt = eg;
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0, '0, 1'b1);
  endtask

  task automatic chk_reset_state();
    chk("rst_gnt_o",     64'(gnt_o),     64'(0));
    chk("rst_valid_o",   64'(valid_o),   64'(0));
    chk("rst_last_o",    64'(last_o),    64'(0));
    chk("rst_data_o",    64'(data_o),    64'(0));
    chk("rst_owner_o",   64'(owner_o),   64'(0));
    chk("rst_locked_o",  64'(locked_o),  64'(0));
    chk("rst_timeout_o", 64'(timeout_o), 64'(0));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  // Monitor: every flit the downstream accepts is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && valid_o && ready_i) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("data_o",      64'(data_o),  64'(e.data));
          chk("last_o",      64'(last_o),  64'(e.last));
          chk("flit_owner",  64'(owner_o), 64'(e.owner));
        end
      end
    end
  end

  initial begin
    int           rem[N];
    int           quiet[N];
    logic [N-1:0] rq, lt;
    logic         rdy;

    model_reset();
    req_i   = '1;
    last_i  = '1;
    ready_i = 1'b1;
    data_i  = '0;
    #12;
    chk_reset_state();

    // All ports single-flit: rotation 0,1,2,3,0.
    repeat (5) tick(4'b1111, 4'b1111, 1'b1);

    // Port 2 three-flit packet while port 1 waits.
    idle(3);
    tick(4'b0100, 4'b0000, 1'b1);
    tick(4'b0110, 4'b0000, 1'b1);
    tick(4'b0110, 4'b0100, 1'b1);
    tick(4'b0110, 4'b0110, 1'b1);

    // Downstream stall for 5 cycles, then resume without a bubble.
    tick(4'b1111, 4'b1111, 1'b1);
    repeat (5) tick(4'b1111, 4'b1111, 1'b0);
    tick(4'b1111, 4'b1111, 1'b1);
    tick(4'b1111, 4'b1111, 1'b1);

    // Owner 1 abandons its packet; forced release, then port 2 beats port 0.
    idle(3);
    tick(4'b0010, 4'b0000, 1'b1);
    idle(6);
    tick(4'b0101, 4'b0101, 1'b1);
    idle(2);

    // Reset in the middle of a locked packet; port 0 first afterwards.
    idle(2);
    tick(4'b1000, 4'b0000, 1'b1);
    tick(4'b1000, 4'b0000, 1'b1);
    mid_reset();
    tick(4'b1111, 4'b1111, 1'b1);
    idle(2);

    // Port 3 alone back-to-back, then port 0 joins after a multi-flit packet.
    repeat (6) tick(4'b1000, 4'b1000, 1'b1);
    tick(4'b1000, 4'b0000, 1'b1);
    tick(4'b1001, 4'b0000, 1'b1);
    tick(4'b1001, 4'b1000, 1'b1);
    tick(4'b1001, 4'b1001, 1'b1);
    idle(3);

    // Randomized traffic with variable packet lengths, stalls and quiet owners.
    for (int k = 0; k < N; k++) begin
      rem[k]   = 0;
      quiet[k] = 0;
    end
    repeat (3000) begin
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0) rem[k] = $urandom_range(1, 4);
        if (quiet[k] == 0 && $urandom_range(0, 39) == 0) quiet[k] = $urandom_range(3, 8);
        if (quiet[k] > 0) begin
          rq[k] = 1'b0;
          quiet[k]--;
        end else begin
          rq[k] = ($urandom_range(0, 3) != 0);
        end
        lt[k] = (rem[k] == 1);
      end
      rdy = ($urandom_range(0, 3) != 0);
      tick(rq, lt, rdy);
      for (int k = 0; k < N; k++) if (last_gnt[k]) rem[k]--;
    end

    idle(10);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
Name: port_arbiter

Overview:
- Wormhole output-port arbiter for a router node.
- Shares one outgoing port among PORTS_NUM competing input ports, round-robin, with packet-level locking.
- Sits between the router's input buffers and the per-node port bundle wired by the topology connector. It owns the output register stage of that port.

Parameters:
- PORTS_NUM, 4, number of requesting input ports.
- DATA_SIZE, 37, flit payload width; the port carries DATA_SIZE plus 2 bits (valid, last).
- LOCK_TIMEOUT, 0, idle cycles an owner may stall mid-packet before forced release; 0 disables.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  PORTS_NUM  per-port flit available
- data_i  in  PORTS_NUM*DATA_SIZE  per-port flit; port k occupies bits [k*DATA_SIZE +: DATA_SIZE]
- last_i  in  PORTS_NUM  per-port flit is packet tail
- gnt_o  out  PORTS_NUM  one-hot pop; the flit of port k is consumed this cycle
- data_o  out  DATA_SIZE  registered output flit
- valid_o  out  1  data_o valid
- last_o  out  1  data_o is tail
- ready_i  in  1  downstream accepts data_o this cycle
- owner_o  out  $clog2(PORTS_NUM)  current or last packet owner
- locked_o  out  1  mid-packet lock held
- timeout_o  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst_n=0): valid_o=0, last_o=0, data_o=0, owner_o=0, locked_o=0, timeout_o=0, state=IDLE, rr pointer=PORTS_NUM-1 (port 0 has first priority), timeout counter=0. gnt_o=0 while rst_n=0.
- Reset mid-packet discards the output register and the lock. No partial-packet recovery.
- Load condition: load_ok = !valid_o || ready_i. Throughput is one flit per cycle.
- gnt_o is combinational. It is 0 whenever load_ok=0, so at most one bit is set.
- IDLE:
  - Winner w = first k with req_i[k], searching from pointer+1 modulo PORTS_NUM.
  - If load_ok and any req: gnt_o[w]=1. Next edge: data_o<=data_i[w], last_o<=last_i[w], valid_o<=1, owner_o<=w.
  - If last_i[w]=1 (single-flit packet): stay IDLE, pointer<=w.
  - Otherwise: state<=LOCKED, locked_o<=1.
- LOCKED:
  - Only the owner is granted: gnt_o[owner]=req_i[owner]&&load_ok. Other requests are ignored.
  - A granted tail flit sets state<=IDLE, locked_o<=0, pointer<=owner.
- Owner drops req while LOCKED: lock is held and bubbles appear on the output (valid_o falls after drain).
  - If LOCK_TIMEOUT>0, the counter increments each LOCKED cycle with no grant and clears on any grant.
  - When the counter reaches LOCK_TIMEOUT: state<=IDLE, pointer<=owner, timeout_o pulses for 1 cycle. The downstream sees a truncated packet.
- Output register drain: if valid_o && ready_i && no load, then valid_o<=0 and last_o<=0. data_o is held.
- Simultaneous drain and load: the new flit replaces the old one with no bubble.
- Latency: grant cycle to valid_o is 1 cycle.
- Pointer wrap: from PORTS_NUM-1 to 0. The pointer updates only at packet end, never per flit.
- owner_o width: $clog2(PORTS_NUM), minimum 1.

Decomposition:
- Shared package/header holds:
  - flit field widths (DATA_SIZE, PORT_SIZE = DATA_SIZE+2)
  - bit positions of valid and last within a port bundle
  - state encoding (IDLE=1'b0, LOCKED=1'b1)
- One sub-module, rr_arbiter:
  - Combinational rotate-priority picker with inputs req and pointer, outputs a one-hot grant and its index.
  - port_arbiter instantiates it and handles lock, output register and timeout.

Test Plan:
- Reset with req_i=4'b1111, then release rst_n → first grant is port 0. With all single-flit packets and ready_i=1, the grant order is 0,1,2,3,0 and valid_o is high every cycle after the first.
- Port 2 sends a 3-flit packet while port 1 requests throughout → gnt_o=0100 for 3 cycles, then port 1 is granted. data_o matches port 2's flits in order and last_o is asserted on the 3rd.
- ready_i=0 for 5 cycles with valid_o=1 → gnt_o=0, data_o stable. Raise ready_i → the next flit loads the same cycle with no bubble.
- LOCK_TIMEOUT=4: owner 1 sends a head flit then drops req → timeout_o pulses 4 idle LOCKED cycles after the head grant, locked_o falls, and the next grant goes to port 2 when ports 0 and 2 request.
- Assert rst_n=0 in the middle of a LOCKED packet → valid_o=0 and locked_o=0 immediately (asynchronous). After release, port 0 has priority.
- Only port 3 requests, packets back-to-back → continuous grants to 3, the pointer stays at 3, and there is no starvation when port 0 joins: port 0 is granted next after port 3's tail.
